// File: rtl/stitch_adapter_pkg.sv
// Shared types and width helpers for the stitched-pipeline credit adapter.
package stitch_adapter_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Credit counter must hold the value depth itself.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Flush down-counter holds latency-1 at most; never narrower than one bit.
    function automatic int flush_w(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/stitch_adapter_fifo.sv
// Synchronous output FIFO; pointers wrap modulo DEPTH so any depth >= 1 works.
module stitch_adapter_fifo
    import stitch_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = credit_w(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/stitch_pipeline_credit_adapter.sv
// Wraps an unreset valid-only pipeline into a ready/valid block: credit-gated
// input, output FIFO, and a post-reset flush of the pipeline's valid chain.
//
//   state    | meaning
//   ST_RESET | rst_n low; FIFO emptied, credits restored
//   ST_FLUSH | LATENCY cycles of zero valids to clear the pipeline
//   ST_RUN   | normal credit-gated operation
module stitch_pipeline_credit_adapter
    import stitch_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 3,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  pipe_in_valid,
    input  logic [DATA_WIDTH-1:0] pipe_out,
    input  logic                  pipe_out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow_err
);

    localparam int CW = credit_w(DEPTH);
    localparam int FW = flush_w(LATENCY);
    localparam logic [CW-1:0] CREDITS_MAX = CW'(DEPTH);
    localparam logic [FW-1:0] FLUSH_LOAD  = FW'(LATENCY - 1);

    state_e        state;
    logic [FW-1:0] flush_cnt;
    logic [CW-1:0] credits;
    logic          overflow_q;
    logic          run;
    logic          accept;
    logic          pop;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;

    // rst_n gating keeps the handshakes quiet in the reset cycle itself.
    assign run           = rst_n && (state == ST_RUN);
    assign in_ready      = run && (credits != '0);
    assign accept        = in_valid && in_ready;
    assign pipe_in_valid = accept;
    assign out_valid     = run && !fifo_empty;
    assign pop           = out_valid && out_ready;
    assign push          = run && pipe_out_valid;
    assign overflow_err  = overflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RESET;
            flush_cnt <= FLUSH_LOAD;
        end else begin
            case (state)
                ST_RESET: begin
                    state     <= ST_FLUSH;
                    flush_cnt <= FLUSH_LOAD;
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_RESET;
            endcase
        end
    end

    // Credits count FIFO slots neither occupied nor promised to in-flight words.
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            credits <= CREDITS_MAX;
        end else if (accept && !pop) begin
            credits <= credits - 1'b1;
        end else if (pop && !accept && (credits != CREDITS_MAX)) begin
            credits <= credits + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    stitch_adapter_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (pipe_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (out_data)
    );

endmodule

// File: tb/tb_stitch_pipeline_credit_adapter.sv
// Bench for stitch_pipeline_credit_adapter with a behavioural LATENCY-deep pipeline and a word scoreboard.
module tb_stitch_pipeline_credit_adapter;

    localparam int DW  = 32;
    localparam int LAT = 3;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          pipe_in_valid;
    logic          pipe_out_valid;
    logic [DW-1:0] pipe_out;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          overflow_err;

    logic [DW-1:0] in_data = 32'd1;
    logic [DW-1:0] inj_data = '0;
    logic          garbage = 1'b0;
    logic          inject = 1'b0;
    logic [LAT-1:0] v_sr;
    logic [DW-1:0] d_sr [LAT];

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            delivered = 0;
    logic [DW-1:0] exp_q [$];
    logic          got_acc = 1'b0;
    logic          got_out = 1'b0;
    int            first_acc = 0;
    int            first_out = 0;
    logic          acc_last = 1'b0;

    stitch_pipeline_credit_adapter #(
        .DATA_WIDTH (DW),
        .LATENCY    (LAT),
        .DEPTH      (DEP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .pipe_in_valid  (pipe_in_valid),
        .pipe_out       (pipe_out),
        .pipe_out_valid (pipe_out_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    // Unreset valid-only pipeline stand-in.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        v_sr  <= {v_sr[LAT-2:0], pipe_in_valid};
        d_sr[0] <= in_data;
        for (int i = 1; i < LAT; i++) d_sr[i] <= d_sr[i-1];
    end

    assign pipe_out_valid = garbage | inject | v_sr[LAT-1];
    assign pipe_out       = inject ? inj_data : d_sr[LAT-1];

    // Scoreboard: accepted words are expected in order at the consumer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            n_cmp++;
            if (pipe_in_valid !== (in_valid && in_ready)) begin
                n_bad++;
                $display("FAIL pipe_in_valid: got %b want %b", pipe_in_valid, in_valid && in_ready);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                if (!got_acc) begin got_acc = 1'b1; first_acc = cyc; end
            end
            if (out_valid && !got_out) begin got_out = 1'b1; first_out = cyc; end
            if (out_valid && out_ready) begin
                delivered++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_extra: got %h want no word", out_data);
                end else begin
                    logic [DW-1:0] w;
                    w = exp_q.pop_front();
                    if (out_data !== w) begin
                        n_bad++;
                        $display("FAIL scoreboard_data: got %h want %h", out_data, w);
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        acc_last = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc_last) in_data = in_data + 1;
    endtask

    task automatic apply_reset(output int edges);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inject = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        edges = 0;
        while (!in_ready && edges < 20) begin step(); edges++; end
        got_acc = 1'b0; got_out = 1'b0; delivered = 0;
    endtask

    task automatic drain(input int want);
        int guard;
        out_ready = 1'b1; in_valid = 1'b0; guard = 0;
        while (delivered < want && guard < 40) begin step(); guard++; end
        out_ready = 1'b0;
        repeat (3) step();
    endtask

    task automatic fill_fifo();
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (DEP) step();
        in_valid = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_reset_flush();
        int  edges;
        logic ov_seen;
        rst_n = 1'b0; garbage = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            step();
            n_cmp++;
            if ({in_ready, pipe_in_valid, out_valid, overflow_err} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_outputs: got %b want 0000", {in_ready, pipe_in_valid, out_valid, overflow_err});
            end
        end
        rst_n = 1'b1; edges = 0; ov_seen = 1'b0;
        while (!in_ready && edges < 20) begin
            step(); edges++;
            if (edges == LAT) garbage = 1'b0;
            if (out_valid) ov_seen = 1'b1;
        end
        in_valid = 1'b0; garbage = 1'b0;
        n_cmp++;
        if (edges != LAT + 1) begin n_bad++; $display("FAIL flush_len: got %0d want %0d", edges, LAT + 1); end
        repeat (6) begin step(); if (out_valid) ov_seen = 1'b1; end
        n_cmp++;
        if (ov_seen !== 1'b0) begin n_bad++; $display("FAIL garbage_valid: got %b want 0", ov_seen); end
        out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        int edges, guard;
        apply_reset(edges);
        n_cmp++;
        if (edges != LAT + 1) begin n_bad++; $display("FAIL stream_flush_len: got %0d want %0d", edges, LAT + 1); end
        in_data = 32'd1; in_valid = 1'b1; out_ready = 1'b1; guard = 0;
        while (in_data <= 32'd16 && guard < 100) begin
            step(); guard++;
            if (in_data == 32'd17) in_valid = 1'b0;
        end
        drain(16);
        n_cmp++;
        if (delivered != 16) begin n_bad++; $display("FAIL stream_count: got %0d want 16", delivered); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL stream_leftover: got %0d want 0", exp_q.size()); end
        n_cmp++;
        if (first_out - first_acc != LAT + 1) begin
            n_bad++; $display("FAIL stream_latency: got %0d want %0d", first_out - first_acc, LAT + 1);
        end
    endtask

    task automatic test_backpressure();
        int edges, acc;
        apply_reset(edges);
        out_ready = 1'b0; in_valid = 1'b1; acc = 0;
        repeat (12) begin step(); if (acc_last) acc++; end
        n_cmp++;
        if (acc != DEP) begin n_bad++; $display("FAIL bp_accepts: got %0d want %0d", acc, DEP); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_credit_return: got %b want 1", in_ready); end
        acc = 0;
        repeat (8) begin step(); if (acc_last) acc++; end
        n_cmp++;
        if (acc != 1) begin n_bad++; $display("FAIL bp_one_more: got %0d want 1", acc); end
        drain(5);
        n_cmp++;
        if (delivered != 5 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL bp_drain: got %0d delivered want 5", delivered);
        end
    endtask

    task automatic test_simultaneous();
        int edges;
        apply_reset(edges);
        fill_fifo();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b10) begin n_bad++; $display("FAIL sim_full_state: got %b want 10", {out_valid, in_ready}); end
        inj_data = 32'hA5A5_0001;
        exp_q.push_back(inj_data);
        inject = 1'b1; out_ready = 1'b1;
        step();
        inject = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL sim_overflow: got %b want 0", overflow_err); end
        drain(DEP + 1);
        n_cmp++;
        if (delivered != DEP + 1 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL sim_drain: got %0d delivered want %0d", delivered, DEP + 1);
        end
        n_cmp++;
        if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL sim_overflow_end: got %b want 0", overflow_err); end
    endtask

    task automatic test_overflow();
        int edges;
        apply_reset(edges);
        fill_fifo();
        inj_data = 32'hDEAD_BEEF;
        inject = 1'b1;
        step();
        inject = 1'b0;
        n_cmp++;
        if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow_err); end
        repeat (5) step();
        drain(DEP);
        n_cmp++;
        if (delivered != DEP || exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL ovf_drop: got %0d delivered valid %b want %0d valid 0", delivered, out_valid, DEP);
        end
        n_cmp++;
        if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
    endtask

    task automatic test_mid_reset();
        int   edges, acc;
        logic seen;
        apply_reset(edges);
        n_cmp++;
        if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow_err); end
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (6) step();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_state: got %b want 1", out_valid); end
        rst_n = 1'b0; in_valid = 1'b0;
        step();
        rst_n = 1'b1; edges = 0; seen = 1'b0;
        while (!in_ready && edges < 20) begin
            step(); edges++;
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (edges != LAT + 1) begin n_bad++; $display("FAIL mid_flush_len: got %0d want %0d", edges, LAT + 1); end
        n_cmp++;
        if (seen !== 1'b0 || delivered != 0) begin n_bad++; $display("FAIL mid_stale: got valid %b want 0", seen); end
        acc = 0; in_valid = 1'b1;
        repeat (10) begin step(); if (acc_last) acc++; end
        in_valid = 1'b0;
        n_cmp++;
        if (acc != DEP) begin n_bad++; $display("FAIL mid_credits: got %0d want %0d", acc, DEP); end
        drain(DEP);
        n_cmp++;
        if (delivered != DEP || exp_q.size() != 0) begin
            n_bad++; $display("FAIL mid_drain: got %0d delivered want %0d", delivered, DEP);
        end
    endtask

    initial begin
        test_reset_flush();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_overflow();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
